// File: rtl/ise_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ise_pkg
// Brief    : Shared constants, FSM state codes and pixel classifier for the
//            image sorting engine statistics stage.
// Revision : 1.0 - initial release
// ============================================================================
package ise_pkg;

    localparam int IMAGE_SIZE  = 128;
    localparam int IMAGE_NUM   = 32;
    localparam int PIX_PER_IMG = IMAGE_SIZE * IMAGE_SIZE;

    // Colour class codes; code 3 is never produced.
    localparam logic [1:0] COL_R = 2'd0;
    localparam logic [1:0] COL_G = 2'd1;
    localparam logic [1:0] COL_B = 2'd2;

    // Statistics stage FSM state codes.
    localparam logic [1:0] ST_ACCUM  = 2'd0;
    localparam logic [1:0] ST_SELECT = 2'd1;
    localparam logic [1:0] ST_DIVIDE = 2'd2;
    localparam logic [1:0] ST_OUTPUT = 2'd3;

    typedef struct packed {
        logic [1:0] color;
        logic [7:0] value;
    } pix_class_t;

    // Dominant channel of a pixel; ties go R over G over B.
    function automatic pix_class_t classify(input logic [23:0] pix);
        pix_class_t res;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        r = pix[23:16];
        g = pix[15:8];
        b = pix[7:0];
        if (r >= g && r >= b) begin
            res.color = COL_R;
            res.value = r;
        end else if (g >= b) begin
            res.color = COL_G;
            res.value = g;
        end else begin
            res.color = COL_B;
            res.value = b;
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ise_img_stat_if.sv
`default_nettype none
// ============================================================================
// Module   : ise_img_stat_if
// Brief    : Pixel-in stream and statistics-record handshake bundle.
//            master = upstream source / sorter side, slave = statistics stage.
// Revision : 1.0 - initial release
// ============================================================================
interface ise_img_stat_if;

    logic [4:0]  image_in_index;
    logic [23:0] pixel_in;
    logic        in_valid;
    logic        busy;
    logic        stat_valid;
    logic        stat_ready;
    logic [4:0]  stat_image_index;
    logic [1:0]  stat_color;
    logic [7:0]  stat_mean;

    modport master (
        output image_in_index, pixel_in, in_valid, stat_ready,
        input  busy, stat_valid, stat_image_index, stat_color, stat_mean
    );

    modport slave (
        input  image_in_index, pixel_in, in_valid, stat_ready,
        output busy, stat_valid, stat_image_index, stat_color, stat_mean
    );

endinterface
`default_nettype wire

// File: rtl/ise_seq_div.sv
`default_nettype none
// ============================================================================
// Module   : ise_seq_div
// Brief    : Restoring unsigned divider, one quotient bit per cycle.
//            start loads operands; done pulses one cycle after the last bit.
// Revision : 1.0 - initial release
// ============================================================================
module ise_seq_div #(
    parameter int DIVIDEND_W = 22,
    parameter int DIVISOR_W  = 15
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    input  wire logic                  start,
    input  wire logic [DIVIDEND_W-1:0] dividend,
    input  wire logic [DIVISOR_W-1:0]  divisor,
    output logic                       done,
    output logic [DIVIDEND_W-1:0]      quotient
);

    localparam int BIT_CNT_W = $clog2(DIVIDEND_W);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DIVIDEND_W - 1);

    logic [DIVISOR_W-1:0]  rem;
    logic [DIVISOR_W-1:0]  dvs;
    logic [DIVIDEND_W-1:0] quo;
    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic                  running;
    logic [DIVISOR_W:0]    trial;
    logic [DIVISOR_W:0]    rem_next;
    logic                  fits;
    logic                  unused_rem_msb;

    // Shift the next dividend bit into the partial remainder and try a subtract.
    always_comb begin
        trial    = {rem, quo[DIVIDEND_W-1]};
        fits     = (trial >= {1'b0, dvs});
        rem_next = fits ? (trial - {1'b0, dvs}) : trial;
    end

    // After a step the remainder is below the divisor, so its MSB is always 0.
    assign unused_rem_msb = rem_next[DIVISOR_W];
    assign quotient       = quo;

    // Operand load on start, then one restoring step per cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem     <= '0;
            dvs     <= '0;
            quo     <= '0;
            bit_cnt <= '0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem     <= '0;
                dvs     <= divisor;
                quo     <= dividend;
                bit_cnt <= '0;
                running <= 1'b1;
            end else if (running) begin
                rem     <= rem_next[DIVISOR_W-1:0];
                quo     <= {quo[DIVIDEND_W-2:0], fits};
                bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                if (bit_cnt == LAST_BIT) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ise_img_stat.sv
`default_nettype none
// ============================================================================
// Module   : ise_img_stat
// Brief    : Per-image dominant-colour statistics. Classifies each pixel,
//            accumulates per-class counts/sums, then emits the winning colour
//            and its mean intensity as one record per image.
// Revision : 1.0 - initial release
// ============================================================================
module ise_img_stat #(
    parameter int IMAGE_SIZE = 128,
    parameter int CNT_W      = 15,
    parameter int SUM_W      = 22
) (
    input  wire logic     clk,
    input  wire logic     reset,
    ise_img_stat_if.slave bus
);
    import ise_pkg::*;

    localparam int PIX_N = IMAGE_SIZE * IMAGE_SIZE;
    localparam int PIX_W = $clog2(PIX_N);
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIX_N - 1);

    logic [1:0]       state;
    logic [PIX_W-1:0] pix_cnt;
    logic [CNT_W-1:0] cnt_r, cnt_g, cnt_b;
    logic [SUM_W-1:0] sum_r, sum_g, sum_b;
    logic [4:0]       img_idx;
    logic [1:0]       win_color;
    logic [1:0]       stat_color_q;
    logic [7:0]       stat_mean_q;

    pix_class_t       pc;
    logic             accept;
    logic             last_pix;
    logic             handshake;
    logic [1:0]       sel_color;
    logic [SUM_W-1:0] sel_sum;
    logic [CNT_W-1:0] sel_cnt;
    logic             div_start;
    logic             div_done;
    logic [SUM_W-1:0] div_quotient;
    logic             unused_quo_hi;

    assign pc        = classify(bus.pixel_in);
    assign accept    = bus.in_valid && (state == ST_ACCUM);
    assign last_pix  = (pix_cnt == PIX_LAST);
    assign handshake = (state == ST_OUTPUT) && bus.stat_ready;
    assign div_start = (state == ST_SELECT);

    // The winner mean never exceeds 255, so only the low quotient byte matters.
    assign unused_quo_hi = ^div_quotient[SUM_W-1:8];

    assign bus.busy             = (state != ST_ACCUM);
    assign bus.stat_valid       = (state == ST_OUTPUT);
    assign bus.stat_image_index = img_idx;
    assign bus.stat_color       = stat_color_q;
    assign bus.stat_mean        = stat_mean_q;

    // Winning class by count; ties go R over G over B.
    always_comb begin
        sel_color = COL_B;
        sel_sum   = sum_b;
        sel_cnt   = cnt_b;
        if (cnt_r >= cnt_g && cnt_r >= cnt_b) begin
            sel_color = COL_R;
            sel_sum   = sum_r;
            sel_cnt   = cnt_r;
        end else if (cnt_g >= cnt_b) begin
            sel_color = COL_G;
            sel_sum   = sum_g;
            sel_cnt   = cnt_g;
        end
    end

    // Per-image accumulation; cleared once the record has been taken.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix_cnt <= '0;
            cnt_r   <= '0;
            cnt_g   <= '0;
            cnt_b   <= '0;
            sum_r   <= '0;
            sum_g   <= '0;
            sum_b   <= '0;
            img_idx <= '0;
        end else if (handshake) begin
            pix_cnt <= '0;
            cnt_r   <= '0;
            cnt_g   <= '0;
            cnt_b   <= '0;
            sum_r   <= '0;
            sum_g   <= '0;
            sum_b   <= '0;
        end else if (accept) begin
            if (pix_cnt == '0) begin
                img_idx <= bus.image_in_index;
            end
            pix_cnt <= last_pix ? '0 : pix_cnt + PIX_W'(1);
            case (pc.color)
                COL_R: begin
                    cnt_r <= cnt_r + CNT_W'(1);
                    sum_r <= sum_r + SUM_W'(pc.value);
                end
                COL_G: begin
                    cnt_g <= cnt_g + CNT_W'(1);
                    sum_g <= sum_g + SUM_W'(pc.value);
                end
                default: begin
                    cnt_b <= cnt_b + CNT_W'(1);
                    sum_b <= sum_b + SUM_W'(pc.value);
                end
            endcase
        end
    end

    // Control FSM and output record registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_ACCUM;
            win_color    <= COL_R;
            stat_color_q <= '0;
            stat_mean_q  <= '0;
        end else begin
            case (state)
                ST_ACCUM: begin
                    if (accept && last_pix) begin
                        state <= ST_SELECT;
                    end
                end
                ST_SELECT: begin
                    win_color <= sel_color;
                    state     <= ST_DIVIDE;
                end
                ST_DIVIDE: begin
                    if (div_done) begin
                        stat_color_q <= win_color;
                        stat_mean_q  <= div_quotient[7:0];
                        state        <= ST_OUTPUT;
                    end
                end
                default: begin
                    if (bus.stat_ready) begin
                        state <= ST_ACCUM;
                    end
                end
            endcase
        end
    end

    ise_seq_div #(
        .DIVIDEND_W (SUM_W),
        .DIVISOR_W  (CNT_W)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .dividend (sel_sum),
        .divisor  (sel_cnt),
        .done     (div_done),
        .quotient (div_quotient)
    );

endmodule
`default_nettype wire

// File: tb/tb_ise_img_stat.sv
`default_nettype none
// ============================================================================
// Module   : tb_ise_img_stat
// Brief    : Directed bench for the image statistics stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ise_img_stat;

    localparam int NPIX = 16384;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    int   records  = 0;

    ise_img_stat_if bus ();

    ise_img_stat dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Count every record handed to the sorter.
    always @(posedge clk) begin
        if (bus.stat_valid === 1'b1 && bus.stat_ready === 1'b1) records <= records + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // mode 0: all a; mode 1: alternate a,b; mode 2: first half a, second half b.
    // Only the first pixel carries the real index; later ones carry a decoy.
    task automatic send_image(input int n, input logic [23:0] a, input logic [23:0] b,
                              input int mode, input logic [4:0] idx);
        for (int i = 0; i < n; i++) begin
            bus.in_valid       = 1'b1;
            bus.image_in_index = (i == 0) ? idx : ~idx;
            case (mode)
                1:       bus.pixel_in = (i % 2 == 1) ? b : a;
                2:       bus.pixel_in = (i < n / 2) ? a : b;
                default: bus.pixel_in = a;
            endcase
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        bus.pixel_in = '0;
    endtask

    // Called right after the last accepting edge; checks latency and fields.
    task automatic wait_record(input string tag, input logic [1:0] color,
                               input logic [7:0] mean, input logic [4:0] idx,
                               input bit ready_high);
        int cyc;
        int busy_cnt;
        cyc      = 0;
        busy_cnt = (bus.busy === 1'b1) ? 1 : 0;
        while (bus.stat_valid !== 1'b1 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (bus.busy === 1'b1) busy_cnt++;
        end
        chk({tag, "_latency"}, cyc, 24);
        chk({tag, "_color"}, bus.stat_color, color);
        chk({tag, "_mean"}, bus.stat_mean, mean);
        chk({tag, "_index"}, bus.stat_image_index, idx);
        if (ready_high) begin
            @(posedge clk); #1;
            if (bus.busy === 1'b1) busy_cnt++;
            chk({tag, "_busy_cycles"}, busy_cnt, 25);
            chk({tag, "_valid_drop"}, bus.stat_valid, 1'b0);
        end
    endtask

    initial begin
        int rec0;
        reset              = 1'b1;
        bus.in_valid       = 1'b0;
        bus.pixel_in       = '0;
        bus.image_in_index = '0;
        bus.stat_ready     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_valid", bus.stat_valid, 1'b0);
        chk("rst_color", bus.stat_color, 2'd0);
        chk("rst_mean", bus.stat_mean, 8'd0);
        chk("rst_index", bus.stat_image_index, 5'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Pure red image.
        send_image(NPIX, 24'hFF0000, 24'h0, 0, 5'd1);
        wait_record("red", 2'd0, 8'd255, 5'd1, 1'b1);

        // Three-way tie per pixel classes as red.
        send_image(NPIX, 24'h101010, 24'h0, 0, 5'd2);
        wait_record("tie3", 2'd0, 8'd16, 5'd2, 1'b1);

        // G/B count tie resolves to G, with sorter backpressure.
        bus.stat_ready = 1'b0;
        send_image(NPIX, 24'h00C800, 24'h000064, 2, 5'd7);
        wait_record("gbtie", 2'd1, 8'd200, 5'd7, 1'b0);
        for (int k = 0; k < 10; k++) begin
            bus.in_valid       = 1'b1;
            bus.pixel_in       = 24'hFFFFFF;
            bus.image_in_index = 5'd31;
            @(posedge clk); #1;
            chk("bp_valid", bus.stat_valid, 1'b1);
            chk("bp_busy", bus.busy, 1'b1);
            chk("bp_color", bus.stat_color, 2'd1);
            chk("bp_mean", bus.stat_mean, 8'd200);
            chk("bp_index", bus.stat_image_index, 5'd7);
        end
        bus.in_valid   = 1'b0;
        bus.stat_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", bus.stat_valid, 1'b0);
        chk("bp_release_busy", bus.busy, 1'b0);

        // Alternating G=1 / G=2: non-exact mean floors to 1.
        send_image(NPIX, 24'h000100, 24'h000200, 1, 5'd9);
        wait_record("alt", 2'd1, 8'd1, 5'd9, 1'b1);

        // Partial image discarded by reset, then a full blue image.
        send_image(5000, 24'hFF0000, 24'h0, 0, 5'd3);
        rec0  = records;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst_busy", bus.busy, 1'b0);
        chk("midrst_valid", bus.stat_valid, 1'b0);
        reset = 1'b0;
        @(posedge clk); #1;
        send_image(NPIX, 24'h0000FF, 24'h0, 0, 5'd4);
        wait_record("blue", 2'd2, 8'd255, 5'd4, 1'b1);
        chk("record_count", records - rec0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ise_img_stat.md
Name: ise_img_stat

Overview:
- Front-end statistics stage of the image sorting engine. Sits directly upstream of the sorter.
- Consumes the raw 24-bit pixel stream, one 128x128 image at a time.
- Classifies every pixel by its dominant channel and accumulates per-class counts and channel sums.
- At end of each image, emits one record per image to the sorter: dominant colour and mean intensity of that colour.

Parameters:
IMAGE_SIZE, 128, image edge length in pixels; PIX_PER_IMG = IMAGE_SIZE*IMAGE_SIZE
CNT_W, 15, class counter width (holds PIX_PER_IMG)
SUM_W, 22, class sum width (holds 255*PIX_PER_IMG)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
image_in_index  in  5  index of image being streamed
pixel_in  in  24  R=[23:16] G=[15:8] B=[7:0]
in_valid  in  1  pixel_in/image_in_index valid this cycle
busy  out  1  high = pixel not accepted; upstream holds data
stat_valid  out  1  output record valid
stat_ready  in  1  sorter accepts record
stat_image_index  out  5  image index of record
stat_color  out  2  0=R 1=G 2=B (3 never produced)
stat_mean  out  8  floor(class channel sum / class count)

Behaviour:
- Reset:
  - All outputs 0 except busy=0.
  - FSM=ACCUM; counters and sums cleared.
  - Reset mid-image or mid-divide discards the partial image; no record is emitted.
- Pixel acceptance: a pixel is accepted when in_valid && !busy on a rising edge.
- Pixel classification (combinational on pixel_in):
  - R if R>=G && R>=B; else G if G>=B; else B.
  - The class counter increments by 1; the class sum adds that pixel's dominant channel value.
- image_in_index is latched on the first pixel of each image; later index values are ignored.
- Pixel counter (14 bit) counts accepted pixels and wraps to 0 at PIX_PER_IMG-1.
- FSM:
  - ACCUM: busy=0. On acceptance of pixel PIX_PER_IMG-1 -> SELECT.
  - SELECT (1 cycle): busy=1. Winner = class with max count; ties resolved R > G > B. Load divider with winner sum/count -> DIVIDE.
  - DIVIDE: busy=1. Sequential divider runs SUM_W (22) cycles; on done -> OUTPUT.
  - OUTPUT: busy=1, stat_valid=1. stat_* fields are held stable until stat_valid && stat_ready. On that handshake edge: stat_valid->0, counters/sums cleared, -> ACCUM, so busy=0 the following cycle.
- Latency:
  - Last pixel accepted at edge N; stat_valid high after edge N+24 (1 SELECT + 22 DIVIDE + 1 register).
  - With stat_ready tied high, busy is high for exactly 25 cycles per image.
- Width rules:
  - Winner count is always >= ceil(PIX_PER_IMG/3), never 0, so the divider needs no divide-by-zero handling.
  - Quotient is always <= 255; stat_mean = quotient[7:0].
- in_valid while busy=1: ignored; no counter or sum changes.
- stat_ready while stat_valid=0: ignored.
- Back-to-back images: the first pixel of the next image is accepted the cycle after busy falls.

Decomposition:
- Shared package ise_pkg:
  - Colour codes COL_R=0, COL_G=1, COL_B=2.
  - IMAGE_SIZE, IMAGE_NUM=32.
  - FSM state enum.
- One sub-module: ise_seq_div. Restoring unsigned divider with start/done handshake, 22-bit dividend, 15-bit divisor, one quotient bit per cycle, 22-bit quotient.

Test Plan:
- One image, all pixels 0xFF0000, stat_ready=1 -> stat_color=0, stat_mean=255. stat_valid at last-accept+24; busy high for 25 cycles.
- All pixels 0x101010 (three-way tie per pixel) -> every pixel classed R; stat_color=0, stat_mean=16.
- 8192 pixels 0x00C800 plus 8192 pixels 0x000064, index 7 -> G/B count tie resolves to G; stat_color=1, stat_mean=200, stat_image_index=7.
- 16384 pixels alternating 0x000100 / 0x000200 -> stat_color=1, stat_mean=1 (floor of 1.5). Also covers the non-exact quotient case.
- Backpressure: stat_ready=0 for 10 cycles after stat_valid rises, in_valid=1 with junk data -> all stat_* fields held stable; busy=1; junk not counted. The next image's stats are unaffected.
- Reset asserted after 5000 pixels of image 3, then a full image 4 of 0x0000FF -> only one record emitted: index 4, color 2, mean 255.
